// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: issues one fetch at a time to instruction memory and
// queues returned {pc, instruction} pairs in a circular buffer for the decode stage.
module if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     STEP     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc,
  input  logic [XLEN-1:0]            PC_Branch,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [ILEN-1:0]            imem_rdata,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [XLEN-1:0]            PC_IF,
  output logic [ILEN-1:0]            INSTRUCTION_IF,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Handshakes: a fetch is transferred in a cycle where imem_req and imem_gnt are both 1;
  // its response arrives later as a single imem_rvalid pulse. Decode takes the queue head
  // in a cycle where if_valid and if_ready are both 1 and no redirect is requested.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // state is kept as a plainly named register so checkers can bind to it directly.
  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [OW-1:0]   occ;
  logic [OW-1:0]   occ_after;
  logic            push;
  logic            pop;
  logic            issue;

  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [ILEN-1:0] ins_q [DEPTH];

  assign if_valid  = (occ != '0);
  assign pop       = if_valid & if_ready & ~PCSrc;
  assign occ_after = occ + OW'(push) - OW'(pop);
  assign occupancy = occ;
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (occ < OW'(DEPTH)) state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req = ~PCSrc;
        if (imem_gnt && !PCSrc) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push      = ~PCSrc;
          state_nxt = (occ_after < OW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A redirect with a response still owed must wait in DROP to swallow it.
    if (PCSrc) begin
      if (!imem_rvalid && (state == S_WAIT || state == S_DROP)) state_nxt = S_DROP;
      else                                                       state_nxt = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
    end else begin
      state <= state_nxt;
      if (PCSrc) begin
        fetch_pc <= PC_Branch;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
      end else begin
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(STEP);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        occ <= occ_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]  <= req_pc;
      ins_q[wr_ptr] <= imem_rdata;
    end
  end

  assign PC_IF          = if_valid ? pc_q[rd_ptr]  : '0;
  assign INSTRUCTION_IF = if_valid ? ins_q[rd_ptr] : ILEN'(NOP_WORD);

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && occ == OW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && occ == '0));

endmodule
